mem_dma: RTL and testbench
==========================

# mem_dma

Word-granular copy engine acting as the initiator on the two-port memory interface: it issues reads on one port and writes on the other. Given source, destination and length, it copies `len` 32-bit words at one word per cycle, pipelined against the responder's fixed one-cycle read latency. It sits between a testbench/CPU control port and any memory exposing the rready/rresp/wready read-write port pair.

## Interface
- `LENW`, default 16: width of the length/counter fields. Maximum transfer is 2^LENW−1 words.
- `clk` in 1: clock.
- `resetb` in 1: reset, asynchronous, active-low.
- `start` in 1: a one-cycle request, sampled only in IDLE.
- `src` in [31:2]: source word address, sampled with `start`.
- `dst` in [31:2]: destination word address, sampled with `start`.
- `len` in LENW: word count, sampled with `start`.
- `busy` out 1: a transfer is in progress.
- `done` out 1: one-cycle completion pulse.
- `rready` out 1: read request.
- `raddr` out [31:2]: read word address.
- `rresp` in 1: read data valid, asserted one cycle after `rready`.
- `rdata` in 32: read data.
- `wready` out 1: write request.
- `waddr` out [31:2]: write word address.
- `wdata` out 32: write data.
- `wstrb` out 4: byte enables.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On `start` with `len`≠0: latch `src`, `dst` and `len`, clear `rcnt` and `wcnt`, go to RUN.
  - On `start` with `len`=0: go to DONE. No memory access is made.
  - `start` outside IDLE is ignored.
- RUN:
  - Drives `rready`=1 and `raddr`=src+rcnt, then increments `rcnt`.
  - After issuing read `len`−1, go to DRAIN.
- Write side, active in RUN and DRAIN:
  - A `pending` flag tracks outstanding reads. `wready` = `rresp` & `pending`.
  - `waddr` = dst+wcnt, `wdata` = `rdata`, `wstrb` = 4'hF.
  - `wcnt` increments on each write.
- DRAIN: when the write with `wcnt`=`len`−1 completes, go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Address arithmetic is modulo 2^30 and wraps silently past 0x3FFFFFFF.
- A `rresp` arriving in IDLE (stale) is ignored and never produces a write.
- Overlap:
  - Correct for non-overlapping ranges and for dst ≤ src.
  - Undefined for src < dst < src+len, because a read may observe a same-cycle write.
- Reset mid-transfer: asynchronously returns to IDLE and clears counters and `pending`. No partial write is issued after reset release, and memory content already written is kept.

## Timing
- Reset values: `busy`=0, `done`=0, `rready`=0, `raddr`=0, `wready`=0, `waddr`=0, `wdata`=0, `wstrb`=0.
- `rready`, `raddr`, `busy` and `done` are registered. `wready`, `waddr`, `wdata` and `wstrb` are combinational from `rresp`/`rdata` and registered counters.
- Cycle sequence, with `start` sampled at edge 0:
  - Reads are issued in cycles 1..len.
  - Writes occur in cycles 2..len+1.
  - `done` is high in cycle len+2.
- `busy` is high in cycles 1..len+1 and low during `done`.
- Throughput is one word per cycle. Total latency from start to done is len+2 cycles. With `len`=0, `done` is high in cycle 1.
- A new `start` is accepted in the cycle after `done`.

## Configuration
- Macro `MEM_DMA_FILL_EN`.
- Defined: adds input ports `mode` (1) and `fill` (32), both sampled with `start`.
  - `mode`=1 selects fill: no reads are issued.
  - `wready`=1 in cycles 1..len, with `wdata`=`fill` and `waddr`=dst+wcnt.
  - `done` is high in cycle len+1.
  - `mode`=0 is identical to copy.
- Undefined: ports absent, copy only.

## Structure
- Package `mem_dma_pkg` holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - `WSTRB_FULL`=4'hF;
  - `MODE_COPY`/`MODE_FILL` constants.
- Sub-module `mem_dma_ctr`: loadable base address plus LENW counter, outputting base+count and a last flag. Instantiated twice, once for the read side and once for the write side.

## Test plan
- Copy: src=0x100>>2, dst=0x400>>2, len=4, source words 0x11111111..0x44444444.
  - Required: writes in cycles 2..5, destination holds the same four words, `done` in cycle 6.
- `len`=0: no `rready`/`wready` ever asserted, `done` in cycle 1.
- Wrap: src=0x3FFFFFFF, len=2. Required: reads addresses 0x3FFFFFFF then 0x00000000.
- Back-to-back: second `start` in the `done` cycle is ignored; `start` one cycle later is accepted.
- Reset asserted during cycle 3 of a len=8 copy: all outputs 0 immediately, only 1–2 words written, no write after release.
- `MEM_DMA_FILL_EN` defined: fill=0xDEADBEEF, len=3. Required: three writes in cycles 1..3 with no reads, `done` in cycle 4.

Source files
------------

// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the mem_dma word copy engine.
package mem_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [3:0] WSTRB_FULL = 4'hF;
  localparam logic       MODE_COPY  = 1'b0;
  localparam logic       MODE_FILL  = 1'b1;

endpackage

// File: rtl/mem_dma_ctr.sv
// Loadable word-address counter: base+count output plus a flag when count hits last_cnt_i.
module mem_dma_ctr
  import mem_dma_pkg::*;
#(
  parameter int unsigned LENW = 16
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            load_i,
  input  logic [31:2]     base_i,
  input  logic            inc_i,
  input  logic [LENW-1:0] last_cnt_i,
  output logic [31:2]     addr_o,
  output logic            last_o
);

  logic [31:2]     addr_q;
  logic [LENW-1:0] cnt_q;

  // Address is carried as its own register so the output is registered and wraps mod 2^30.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      addr_q <= base_i;
      cnt_q  <= '0;
    end else if (inc_i) begin
      addr_q <= addr_q + 30'd1;
      cnt_q  <= cnt_q + LENW'(1);
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == last_cnt_i);

endmodule

// File: rtl/mem_dma.sv
// Word copy engine: reads one port, writes the other, one word per cycle.
// Optional fill mode (no reads, constant write data) enabled by MEM_DMA_FILL_EN.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int unsigned LENW = 16
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            start_i,
  input  logic [31:2]     src_i,
  input  logic [31:2]     dst_i,
  input  logic [LENW-1:0] len_i,
`ifdef MEM_DMA_FILL_EN
  input  logic            mode_i,
  input  logic [31:0]     fill_i,
`endif
  output logic            busy_o,
  output logic            done_o,
  output logic            rready_o,
  output logic [31:2]     raddr_o,
  input  logic            rresp_i,
  input  logic [31:0]     rdata_i,
  output logic            wready_o,
  output logic [31:2]     waddr_o,
  output logic [31:0]     wdata_o,
  output logic [3:0]      wstrb_o
);

  state_e          state_q, state_d;
  logic [LENW-1:0] len_q;
  logic            rready_q, rready_d;
  logic            busy_q, done_q, pending_q;
  logic            mode_q, start_mode;
  logic            accept, start_fill, fill_mode;
  logic            rd_inc, rd_last, wr_last;
  logic            copy_wr, fill_wr, xfer_st;
  logic [31:2]     wr_addr;
  logic [31:0]     fill_data;

`ifdef MEM_DMA_FILL_EN
  logic [31:0] fill_q;
  assign start_mode = mode_i;
  assign fill_data  = fill_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)     fill_q <= '0;
    else if (accept) fill_q <= fill_i;
  end
`else
  assign start_mode = MODE_COPY;
  assign fill_data  = '0;
`endif

  assign accept     = (state_q == ST_IDLE) && start_i && (len_i != '0);
  assign start_fill = (start_mode == MODE_FILL);
  assign fill_mode  = (mode_q == MODE_FILL);
  assign xfer_st    = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  // pending mirrors the one-cycle read latency, so stale rresp in IDLE/DONE never writes.
  assign copy_wr  = rresp_i && pending_q && !fill_mode && xfer_st;
  assign fill_wr  = fill_mode && (state_q == ST_RUN);
  assign wready_o = copy_wr || fill_wr;
  assign waddr_o  = wready_o ? wr_addr : '0;
  assign wdata_o  = !wready_o ? '0 : (fill_mode ? fill_data : rdata_i);
  assign wstrb_o  = wready_o ? WSTRB_FULL : '0;

  mem_dma_ctr #(.LENW(LENW)) u_rd_ctr (
    .clk        (clk),
    .resetb     (resetb),
    .load_i     (accept),
    .base_i     (src_i),
    .inc_i      (rd_inc),
    .last_cnt_i (len_q - LENW'(1)),
    .addr_o     (raddr_o),
    .last_o     (rd_last)
  );

  mem_dma_ctr #(.LENW(LENW)) u_wr_ctr (
    .clk        (clk),
    .resetb     (resetb),
    .load_i     (accept),
    .base_i     (dst_i),
    .inc_i      (wready_o),
    .last_cnt_i (len_q - LENW'(1)),
    .addr_o     (wr_addr),
    .last_o     (wr_last)
  );

  always_comb begin
    state_d  = state_q;
    rready_d = 1'b0;
    rd_inc   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = (len_i != '0) ? ST_RUN : ST_DONE;
          rready_d = (len_i != '0) && !start_fill;
        end
      end
      ST_RUN: begin
        if (fill_mode) begin
          if (wr_last) state_d = ST_DONE;
        end else begin
          rd_inc = 1'b1;
          if (rd_last) state_d  = ST_DRAIN;
          else         rready_d = 1'b1;
        end
      end
      ST_DRAIN: if (wready_o && wr_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= ST_IDLE;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
      len_q     <= '0;
      mode_q    <= MODE_COPY;
    end else begin
      state_q   <= state_d;
      rready_q  <= rready_d;
      busy_q    <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q    <= (state_d == ST_DONE);
      pending_q <= rready_q;
      if (accept) begin
        len_q  <= len_i;
        mode_q <= start_mode;
      end
    end
  end

  assign rready_o = rready_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: memory responder, per-cycle transfer model, directed + random transfers.
module tb_mem_dma;

  localparam int unsigned LENW = 16;

  logic            clk = 1'b0;
  logic            resetb = 1'b0;
  logic            start_i = 1'b0;
  logic [31:2]     src_i = '0;
  logic [31:2]     dst_i = '0;
  logic [LENW-1:0] len_i = '0;
  logic            mode_i = 1'b0;
  logic [31:0]     fill_i = '0;
  logic            busy_o, done_o, rready_o, wready_o, rresp_i;
  logic [31:2]     raddr_o, waddr_o;
  logic [31:0]     rdata_i, wdata_o;
  logic [3:0]      wstrb_o;

  logic            rresp_q, stale;
  logic [31:0]     rdata_q;

  assign rresp_i = rresp_q | stale;
  assign rdata_i = rdata_q;

  mem_dma #(.LENW(LENW)) dut (
    .clk      (clk),
    .resetb   (resetb),
    .start_i  (start_i),
    .src_i    (src_i),
    .dst_i    (dst_i),
    .len_i    (len_i),
`ifdef MEM_DMA_FILL_EN
    .mode_i   (mode_i),
    .fill_i   (fill_i),
`endif
    .busy_o   (busy_o),
    .done_o   (done_o),
    .rready_o (rready_o),
    .raddr_o  (raddr_o),
    .rresp_i  (rresp_i),
    .rdata_i  (rdata_i),
    .wready_o (wready_o),
    .waddr_o  (waddr_o),
    .wdata_o  (wdata_o),
    .wstrb_o  (wstrb_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: unwritten words read back as an address-derived pattern.
  logic [31:0] mem [logic [29:0]];
  int unsigned wr_total = 0;

  function automatic logic [31:0] rdmem(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return {2'b00, a} ^ 32'hC3A5_0000;
  endfunction

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rresp_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      rresp_q <= rready_o;
      rdata_q <= rready_o ? rdmem(raddr_o) : $urandom;
      if (wready_o) begin
        mem[waddr_o] = wdata_o;
        wr_total     = wr_total + 1;
      end
    end
  end

  // Transfer model: one descriptor, expected outputs derived from the cycle offset since start.
  bit          m_valid = 0;
  int unsigned m_base = 0;
  logic [29:0] m_src, m_dst;
  int          m_len = 0;
  bit          m_fill = 0;
  logic [31:0] m_fillval;
  logic [31:0] snap [64];
  int          st_rd, st_wr, st_wfirst, st_wlast, st_done;
  logic [29:0] st_ra [2];

  function automatic int done_cycle();
    if (m_len == 0) return 1;
    return m_fill ? m_len + 1 : m_len + 2;
  endfunction

  always @(negedge clk) begin
    int          c;
    bit          e_busy, e_done, e_rr, e_wr;
    logic [29:0] e_ra, e_wa;
    logic [31:0] e_wd;
    if (!resetb) begin
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_rready", rready_o, 0);
      chk("rst_raddr", raddr_o, 0);
      chk("rst_wready", wready_o, 0);
      chk("rst_waddr", waddr_o, 0);
      chk("rst_wdata", wdata_o, 0);
      chk("rst_wstrb", wstrb_o, 0);
    end else begin
      e_busy = 0; e_done = 0; e_rr = 0; e_wr = 0;
      e_ra = '0; e_wa = '0; e_wd = '0;
      c = int'(cyc - m_base);
      if (m_valid) begin
        if (m_len == 0) begin
          e_done = (c == 1);
        end else if (m_fill) begin
          e_busy = (c >= 1) && (c <= m_len);
          e_wr   = e_busy;
          e_done = (c == m_len + 1);
          e_wa   = m_dst + 30'(c - 1);
          e_wd   = m_fillval;
        end else begin
          e_busy = (c >= 1) && (c <= m_len + 1);
          e_rr   = (c >= 1) && (c <= m_len);
          e_wr   = (c >= 2) && (c <= m_len + 1);
          e_done = (c == m_len + 2);
          e_ra   = m_src + 30'(c - 1);
          e_wa   = m_dst + 30'(c - 2);
          if (e_wr) e_wd = snap[c - 2];
        end
      end
      chk("busy", busy_o, e_busy);
      chk("done", done_o, e_done);
      chk("rready", rready_o, e_rr);
      chk("wready", wready_o, e_wr);
      chk("wstrb", wstrb_o, e_wr ? 4'hF : 4'h0);
      if (e_rr) chk("raddr", raddr_o, e_ra);
      if (e_wr) begin
        chk("waddr", waddr_o, e_wa);
        chk("wdata", wdata_o, e_wd);
      end
      if (m_valid) begin
        if (rready_o) begin
          if (st_rd < 2) st_ra[st_rd] = raddr_o;
          st_rd++;
        end
        if (wready_o) begin
          if (st_wr == 0) st_wfirst = c;
          st_wlast = c;
          st_wr++;
        end
        if (done_o) st_done = c;
      end
    end
  end

  // Called at negedge+1: start is sampled at the following posedge (edge 0).
  task automatic launch(input logic [29:0] s, input logic [29:0] d, input int l,
                        input bit f, input logic [31:0] fv);
    start_i = 1'b1;
    src_i   = s;
    dst_i   = d;
    len_i   = LENW'(l);
    mode_i  = f;
    fill_i  = fv;
    m_valid = 1; m_base = cyc; m_src = s; m_dst = d; m_len = l;
    m_fill = f; m_fillval = fv;
    for (int k = 0; k < l && k < 64; k++) snap[k] = rdmem(s + 30'(k));
    st_rd = 0; st_wr = 0; st_wfirst = -1; st_wlast = -1; st_done = -1;
    @(negedge clk); #1;
    start_i = 1'b0;
    src_i   = $urandom;
    dst_i   = $urandom;
    len_i   = LENW'($urandom);
    mode_i  = 1'($urandom);
    fill_i  = $urandom;
  endtask

  task automatic wait_done();
    while (int'(cyc - m_base) < done_cycle()) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic check_mem();
    for (int k = 0; k < m_len; k++)
      chk("mem_dst", rdmem(m_dst + 30'(k)), m_fill ? m_fillval : snap[k]);
  endtask

  task automatic go(input logic [29:0] s, input logic [29:0] d, input int l,
                    input bit f, input logic [31:0] fv);
    @(negedge clk); #1;
    launch(s, d, l, f, fv);
    wait_done();
    check_mem();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1);
  end

  initial begin
    logic [29:0] s, d;
    int          l, gap;
    bit          f;
    int unsigned w0, w1;
    logic [31:0] ref_word;

    stale = 1'b0;
    repeat (3) @(negedge clk);
    #1 resetb = 1'b1;

    // Directed copy of four known words.
    for (int k = 0; k < 4; k++) mem[30'h40 + 30'(k)] = 32'h1111_1111 * (k + 1);
    go(30'h40, 30'h100, 4, 0, '0);
    chk("copy_wfirst", st_wfirst, 2);
    chk("copy_wlast", st_wlast, 5);
    chk("copy_done", st_done, 6);
    chk("copy_wcount", st_wr, 4);
    for (int k = 0; k < 4; k++) begin
      ref_word = 32'h1111_1111 * (k + 1);
      chk("copy_dst", rdmem(30'h100 + 30'(k)), ref_word);
    end

    go(30'h200, 30'h300, 0, 0, '0);
    chk("len0_reads", st_rd, 0);
    chk("len0_writes", st_wr, 0);
    chk("len0_done", st_done, 1);

    go(30'h3FFF_FFFF, 30'h500, 2, 0, '0);
    chk("wrap_ra0", st_ra[0], 32'h3FFF_FFFF);
    chk("wrap_ra1", st_ra[1], 32'h0);

    // Start during the done cycle is ignored; one cycle later it is taken.
    go(30'h600, 30'h700, 2, 0, '0);
    start_i = 1'b1; src_i = 30'h10; dst_i = 30'h20; len_i = 7;
    @(negedge clk); #1;
    launch(30'h800, 30'h900, 3, 0, '0);
    wait_done();
    check_mem();
    chk("b2b_done", st_done, 5);
    chk("b2b_wcount", st_wr, 3);

    // Reset during cycle 3 of an 8-word copy.
    @(negedge clk); #1;
    w0 = wr_total;
    launch(30'h1000, 30'h2000, 8, 0, '0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    resetb = 1'b0;
    m_valid = 0;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_rready", rready_o, 0);
    chk("midrst_wready", wready_o, 0);
    chk("midrst_raddr", raddr_o, 0);
    chk("midrst_waddr", waddr_o, 0);
    chk("midrst_wstrb", wstrb_o, 0);
    chk("midrst_writes_1to2", ((wr_total - w0) >= 1) && ((wr_total - w0) <= 2), 1);
    chk("midrst_kept", rdmem(30'h2000), snap[0]);
    @(negedge clk); #1 resetb = 1'b1;
    w1 = wr_total;
    repeat (10) @(negedge clk);
    #1;
    chk("midrst_no_write_after", wr_total, w1);

`ifdef MEM_DMA_FILL_EN
    go(30'hA00, 30'hB00, 3, 1, 32'hDEAD_BEEF);
    chk("fill_wfirst", st_wfirst, 1);
    chk("fill_wlast", st_wlast, 3);
    chk("fill_done", st_done, 4);
    chk("fill_reads", st_rd, 0);
`endif

    // Random transfers with stale rresp pulses between them.
    for (int i = 0; i < 30; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(negedge clk); #1;
        stale = 1'($urandom_range(0, 1));
      end
      stale = 1'b0;
      s = 30'($urandom);
      l = $urandom_range(0, 12);
      if ($urandom_range(0, 3) == 0) d = s - 30'($urandom_range(0, 3));
      else                           d = s + 30'h1_0000 + 30'($urandom_range(0, 4095));
`ifdef MEM_DMA_FILL_EN
      f = 1'($urandom_range(0, 1));
`else
      f = 1'b0;
`endif
      go(s, d, l, f, $urandom);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
